// File: rtl/blink_rtc_int.sv
// ---------------------------------------------------------------------------
// blink_rtc_int -- 5 ms tick real-time clock with status/mask interrupt.
//
// A prescaler (tck) divides mck down to a 5 ms tick. Ticks feed a cascade of
// counters: tim0 (ticks per second), tim1 (seconds per minute) and timm
// (free-running minute count, modulo 2^TM_W). Tick, second and minute events
// set sticky status bits tsta[2:0]. They are acknowledged by writing 0xB4 and
// masked by tmk (0xB5). int_n is low while any unmasked status bit is set.
//
// Optional feature: define BLINK_RTC_SNAPSHOT_EN to add a shadow register.
// A read of 0xD0 captures tim1/timm so that 0xD1..0xD4 return a coherent
// time. Without the macro, 0xD1..0xD4 read the live counters.
//
// Ports:
//   mck       in   master clock (all state on rising edge)
//   rin       in   asynchronous active-high reset
//   io_wr     in   single-cycle IO write strobe
//   io_rd     in   single-cycle IO read strobe
//   io_addr   in   [7:0] IO port address
//   io_wdata  in   [7:0] write data
//   io_rdata  out  [7:0] registered read data
//   rtc_hold  in   level; holds tick/time counters at zero
//   int_n     out  active-low interrupt request
//   tick      out  one-cycle pulse per 5 ms tick
// ---------------------------------------------------------------------------
module blink_rtc_int #(
    parameter int TCK_DIV = 49152,
    parameter int T0_MAX  = 199,
    parameter int T1_MAX  = 59,
    parameter int TM_W    = 21
) (
    input  logic       mck,
    input  logic       rin,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    input  logic       rtc_hold,
    output logic       int_n,
    output logic       tick
);

    localparam logic [15:0] TCK_LAST = 16'(TCK_DIV - 1);
    localparam logic [7:0]  T0_LAST  = 8'(T0_MAX);
    localparam logic [5:0]  T1_LAST  = 6'(T1_MAX);

    localparam logic [7:0] A_TACK = 8'hB4;
    localparam logic [7:0] A_TMK  = 8'hB5;
    localparam logic [7:0] A_TIM0 = 8'hD0;
    localparam logic [7:0] A_TIM1 = 8'hD1;
    localparam logic [7:0] A_TM0  = 8'hD2;
    localparam logic [7:0] A_TM1  = 8'hD3;
    localparam logic [7:0] A_TM2  = 8'hD4;

    logic [15:0]     tck;
    logic [7:0]      tim0;
    logic [5:0]      tim1;
    logic [TM_W-1:0] timm;
    logic [2:0]      tsta;
    logic [2:0]      tmk;

    logic            tck_wrap;
    logic            sec_ev;
    logic            min_ev;
    logic [2:0]      tack_clr;
    logic [5:0]      rd_tim1;
    logic [TM_W-1:0] rd_timm;
    logic [23:0]     rd_timm24;

    // Events are suppressed entirely while held; the cascade is combinational
    // so tick, sec and min all fire on the same edge.
    assign tck_wrap = (tck == TCK_LAST) && !rtc_hold;
    assign sec_ev   = tck_wrap && (tim0 == T0_LAST);
    assign min_ev   = sec_ev && (tim1 == T1_LAST);
    assign tack_clr = (io_wr && io_addr == A_TACK) ? io_wdata[2:0] : 3'b000;

    assign int_n = ~|(tsta & tmk);

    // Only the low three write-data bits are architecturally meaningful.
    logic unused_wdata;
    assign unused_wdata = ^io_wdata[7:3];

    // Prescaler and time counters
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            tck  <= '0;
            tim0 <= '0;
            tim1 <= '0;
            timm <= '0;
            tick <= 1'b0;
        end else if (rtc_hold) begin
            tck  <= '0;
            tim0 <= '0;
            tim1 <= '0;
            timm <= '0;
            tick <= 1'b0;
        end else begin
            tick <= tck_wrap;
            if (tck_wrap) begin
                tck  <= '0;
                tim0 <= (tim0 == T0_LAST) ? 8'd0 : tim0 + 8'd1;
                if (sec_ev)
                    tim1 <= (tim1 == T1_LAST) ? 6'd0 : tim1 + 6'd1;
                if (min_ev)
                    timm <= timm + 1'b1;
            end else begin
                tck <= tck + 16'd1;
            end
        end
    end

    // Status and mask. Set has priority over a same-cycle acknowledge.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            tsta <= '0;
            tmk  <= '0;
        end else begin
            tsta <= (tsta & ~tack_clr) | {min_ev, sec_ev, tck_wrap};
            if (io_wr && io_addr == A_TMK)
                tmk <= io_wdata[2:0];
        end
    end

`ifdef BLINK_RTC_SNAPSHOT_EN
    logic [5:0]      shd_tim1;
    logic [TM_W-1:0] shd_timm;

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            shd_tim1 <= '0;
            shd_timm <= '0;
        end else if (io_rd && io_addr == A_TIM0) begin
            shd_tim1 <= tim1;
            shd_timm <= timm;
        end
    end

    assign rd_tim1 = shd_tim1;
    assign rd_timm = shd_timm;
`else
    assign rd_tim1 = tim1;
    assign rd_timm = timm;
`endif

    // Zero-extend so bits at or above TM_W read back as 0.
    assign rd_timm24 = 24'(rd_timm);

    // Read port: reflects state before the current edge, so a simultaneous
    // write/acknowledge is not visible in the returned data.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            io_rdata <= '0;
        end else if (io_rd) begin
            case (io_addr)
                A_TMK:   io_rdata <= {5'b0, tsta};
                A_TIM0:  io_rdata <= tim0;
                A_TIM1:  io_rdata <= {2'b0, rd_tim1};
                A_TM0:   io_rdata <= rd_timm24[7:0];
                A_TM1:   io_rdata <= rd_timm24[15:8];
                A_TM2:   io_rdata <= rd_timm24[23:16];
                default: io_rdata <= io_rdata;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_rtc_int.sv
// ---------------------------------------------------------------------------
// tb_blink_rtc_int -- self-checking bench for blink_rtc_int.
// Small parameters (4-cycle tick, 3 ticks/sec, 2 sec/min, 8-bit minutes)
// keep every cascade and the minute wrap reachable in a short run.
// ---------------------------------------------------------------------------
module tb_blink_rtc_int;

    localparam int TD = 4;
    localparam int T0 = 2;
    localparam int T1 = 1;
    localparam int TW = 8;
`ifdef BLINK_RTC_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic       mck = 1'b0;
    logic       rin = 1'b1;
    logic       io_wr = 1'b0;
    logic       io_rd = 1'b0;
    logic [7:0] io_addr = 8'h00;
    logic [7:0] io_wdata = 8'h00;
    logic [7:0] io_rdata;
    logic       rtc_hold = 1'b0;
    logic       int_n;
    logic       tick;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    blink_rtc_int #(.TCK_DIV(TD), .T0_MAX(T0), .T1_MAX(T1), .TM_W(TW)) dut (
        .mck(mck), .rin(rin), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .rtc_hold(rtc_hold),
        .int_n(int_n), .tick(tick)
    );

    always #5 mck = ~mck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is the number of counting edges since counters were last zeroed;
    // every visible quantity is derived from it with plain arithmetic.
    int m_n = 0;
    int m_tsta = 0;
    int m_tmk = 0;
    int m_rdata = 0;
    int m_tick = 0;
    int m_sh1 = 0;
    int m_shm = 0;

    function automatic int f_tim0(int n); return (n / TD) % (T0 + 1); endfunction
    function automatic int f_tim1(int n); return (n / TD / (T0 + 1)) % (T1 + 1); endfunction
    function automatic int f_timm(int n); return (n / TD / (T0 + 1) / (T1 + 1)) % (1 << TW); endfunction

    always @(posedge mck or posedge rin) begin
        int t0, t1, tm, r1, rm, ev, ticks, clr;
        if (rin) begin
            m_n = 0; m_tsta = 0; m_tmk = 0; m_rdata = 0; m_tick = 0; m_sh1 = 0; m_shm = 0;
        end else begin
            t0 = f_tim0(m_n); t1 = f_tim1(m_n); tm = f_timm(m_n);
            r1 = SNAP ? m_sh1 : t1;
            rm = SNAP ? m_shm : tm;
            if (io_rd) begin
                case (io_addr)
                    8'hB5: m_rdata = m_tsta;
                    8'hD0: m_rdata = t0;
                    8'hD1: m_rdata = r1;
                    8'hD2: m_rdata = rm & 255;
                    8'hD3: m_rdata = (rm >> 8) & 255;
                    8'hD4: m_rdata = (rm >> 16) & 255;
                    default: ;
                endcase
                if (io_addr == 8'hD0) begin m_sh1 = t1; m_shm = tm; end
            end
            ev = 0;
            if (rtc_hold) begin
                m_n = 0;
            end else begin
                m_n++;
                ticks = m_n / TD;
                if (m_n % TD == 0) begin
                    ev = 1;
                    if (ticks % (T0 + 1) == 0) ev = 3;
                    if (ticks % ((T0 + 1) * (T1 + 1)) == 0) ev = 7;
                end
            end
            m_tick = ev & 1;
            clr = (io_wr && io_addr == 8'hB4) ? int'(io_wdata[2:0]) : 0;
            m_tsta = (m_tsta & ~clr & 7) | ev;
            if (io_wr && io_addr == 8'hB5) m_tmk = int'(io_wdata[2:0]);
        end
    end

    always @(negedge mck) begin
        if (cmp_en) begin
            chk("tick", 32'(tick), 32'(m_tick));
            chk("int_n", 32'(int_n), ((m_tsta & m_tmk) != 0) ? 32'd0 : 32'd1);
            chk("io_rdata", 32'(io_rdata), 32'(m_rdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        io_wr = 1'b1; io_addr = a; io_wdata = d;
        @(posedge mck); #1;
        io_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        io_rd = 1'b1; io_addr = a;
        @(posedge mck); #1;
        io_rd = 1'b0;
        @(negedge mck);
        chk(name, 32'(io_rdata), 32'(exp));
    endtask

    logic [7:0] addr_tbl [8] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hB5, 8'h00, 8'hB4};

    initial begin
        repeat (3) @(posedge mck);
        @(negedge mck);
        chk("rst_rdata", 32'(io_rdata), 32'd0);
        chk("rst_int_n", 32'(int_n), 32'd1);
        chk("rst_tick", 32'(tick), 32'd0);
        cmp_en = 1'b1;

        // Release and unmask tick: first tick after 4 counting edges.
        rin = 1'b0;
        wr(8'hB5, 8'h01);                       // edge 1
        repeat (2) @(posedge mck);              // edges 2,3
        @(negedge mck);
        chk("pre_tick", 32'(tick), 32'd0);
        @(posedge mck); @(negedge mck);         // edge 4
        chk("first_tick", 32'(tick), 32'd1);
        chk("first_int", 32'(int_n), 32'd0);

        // One full minute at edge 24, second at edge 48.
        repeat (20) @(posedge mck); #1;
        rd(8'hD2, 8'd1, "timm_1min");
        rd(8'hB5, 8'd7, "tsta_all");
        repeat (22) @(posedge mck); #1;
        rd(8'hD2, 8'd2, "timm_2min");

        // Acknowledge on the tick edge (52): set wins.
        repeat (2) @(posedge mck); #1;
        wr(8'hB4, 8'h01);
        @(negedge mck);
        chk("set_wins", 32'(int_n), 32'd0);
        wr(8'hB4, 8'h07);
        @(negedge mck);
        chk("ack_clear", 32'(int_n), 32'd1);
        rd(8'hB5, 8'd0, "tsta_cleared");

        // Hold for 10 edges starting after the tick at edge 56.
        repeat (3) @(posedge mck); #1;
        rtc_hold = 1'b1;
        @(posedge mck); #1;
        rd(8'hD0, 8'd0, "hold_d0");
        rd(8'hD1, 8'd0, "hold_d1");
        rd(8'hD2, 8'd0, "hold_d2");
        rd(8'hD3, 8'd0, "hold_d3");
        rd(8'hD4, 8'd0, "hold_d4");
        rd(8'hB5, 8'd1, "hold_tsta");
        repeat (3) @(posedge mck); #1;
        rtc_hold = 1'b0;
        repeat (3) @(posedge mck);
        @(negedge mck);
        chk("hold_no_tick", 32'(tick), 32'd0);
        @(posedge mck); @(negedge mck);
        chk("hold_rel_tick", 32'(tick), 32'd1);

        // Full mask, then async reset mid-read right on a minute event.
        wr(8'hB5, 8'h07);
        repeat (19) @(posedge mck); #1;
        io_rd = 1'b1; io_addr = 8'hD0;
        #2 rin = 1'b1;
        #1;
        chk("arst_rdata", 32'(io_rdata), 32'd0);
        chk("arst_int_n", 32'(int_n), 32'd1);
        chk("arst_tick", 32'(tick), 32'd0);
        @(posedge mck); #1;
        rin = 1'b0; io_rd = 1'b0;
        repeat (3) @(posedge mck);
        @(negedge mck);
        chk("post_rst_quiet", 32'(tick), 32'd0);
        @(posedge mck); @(negedge mck);
        chk("post_rst_tick", 32'(tick), 32'd1);

        // Long mixed run: rotating reads, sparse writes (incl. unlisted
        // address), a hold burst, and enough minutes to wrap timm.
        for (int i = 0; i < 6600; i++) begin
            io_rd    = 1'b1;
            io_addr  = addr_tbl[i % 8];
            io_wr    = (i % 37 == 0);
            if (i % 111 == 0) begin io_wr = 1'b1; io_addr = 8'hB6; end
            io_wdata = 8'($urandom);
            rtc_hold = (i >= 100 && i < 113);
            @(negedge mck);
        end
        io_rd = 1'b0; io_wr = 1'b0; rtc_hold = 1'b0;
        @(negedge mck);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
